fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-side arbiter that shares one sys_fifo write port between two
//  16-bit producers. Each producer has a valid/ready handshake. The winner keeps the
//  grant for a burst of up to MAX_BURST beats. The block stalls on fifo_full and keeps
//  per-port accepted-word counters. Sits directly in front of sys_fifo (wr_en/data_in/full).
// PARAMETERS
//  DATA_W     16  data width (matches sys_fifo data_in)
//  MAX_BURST  4   max consecutive beats per grant; >=1
//  CNT_W      16  width of per-port accepted-word counters
// PORTS
//  clk           in   1       system clock; everything on posedge
//  rst           in   1       reset; synchronous, active-high
//  s0_valid      in   1       port 0 has a word
//  s0_data       in   DATA_W  port 0 word
//  s0_ready      out  1       port 0 word accepted this cycle when s0_valid&s0_ready
//  s1_valid      in   1       port 1 has a word
//  s1_data       in   DATA_W  port 1 word
//  s1_ready      out  1       port 1 accept
//  fifo_full     in   1       sys_fifo full
//  fifo_wr_en    out  1       sys_fifo write strobe
//  fifo_data_in  out  DATA_W  sys_fifo write data
//  busy          out  1       state != IDLE
//  cnt0, cnt1    out  CNT_W   words accepted from port 0/1; wrap modulo 2^CNT_W
// BEHAVIOUR
//  - Registered state: st {IDLE,GNT0,GNT1}, beat (0..MAX_BURST), last (last served port).
//  - Reset (rst=1 at posedge): st=IDLE, beat=0, last=1 (port 0 wins first tie),
//    cnt0=cnt1=0. With valids low: fifo_wr_en=0, s*_ready=0, fifo_data_in=0, busy=0.
//  - Combinational owner:
//    - GNTi: owner=i.
//    - IDLE, both valid: owner=~last.
//    - IDLE, only one valid: that port.
//    - IDLE, neither valid: none.
//  - si_ready = (owner==i) & ~fifo_full.
//    xfer_i = si_valid & si_ready.
//    fifo_wr_en = xfer_0|xfer_1.
//    fifo_data_in = owner's data; 0 when no owner. Zero-latency path, no pipeline.
//  - Producer rule: valid, once high, holds with stable data until accepted.
//  - IDLE, xfer_i: c=1. IDLE, no xfer (fifo_full or no valid): stay IDLE, last unchanged.
//  - GNTi, xfer_i: c=beat+1.
//  - After any xfer_i:
//    - c==MAX_BURST -> IDLE, beat=0, last=i (next cycle re-arbitrates, no bubble).
//    - Otherwise -> GNTi, beat=c.
//  - GNTi, si_valid=0 -> IDLE, beat=0, last=i. This costs one dead cycle.
//  - GNTi, si_valid=1, fifo_full=1: hold st/beat; ready=0, wr_en=0.
//  - cnt_i increments by 1 on every xfer_i; wraps all-ones -> 0.
//  - At most one xfer per cycle. The non-owner's ready is always 0.
//  - rst overrides everything in the same edge. A mid-burst reset drops the grant;
//    an unaccepted word stays with its producer.
// TESTING
//  1 rst=1 3 cycles, valids 0 -> fifo_wr_en=0, readys=0, data_in=0, busy=0, cnt0=cnt1=0.
//  2 s0 streams 10 words 3..12, s1 idle, full=0 -> wr_en high 10 consecutive cycles,
//    data_in 3..12 in order (no gap at beat 4/8), cnt0=10, cnt1=0.
//  3 s0,s1 always valid, MAX_BURST=4, full=0 -> grant pattern 0,0,0,0,1,1,1,1,0...;
//    after 16 cycles cnt0=cnt1=8.
//  4 full=1 for 3 cycles after beat 2 of s0 burst -> ready/wr_en low 3 cycles, data_in held.
//    Then beats 3,4 complete; no loss or duplicate; cnt0 exact.
//  5 s0 owns (GNT0), drops valid, s1 waiting -> 1 cycle wr_en=0, then s1_ready=1.
//  6 rst pulsed mid-burst of s1, both valid -> next cycle st=IDLE, cnt=0, port 0 granted.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Two producer valid/ready channels plus the sys_fifo write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;
    logic              s0_ready;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_data_in;

    // Arbiter side: consumes producer words, drives the fifo write port.
    modport slave (
        input  s0_valid, s0_data, s1_valid, s1_data, fifo_full,
        output s0_ready, s1_ready, fifo_wr_en, fifo_data_in
    );

    // Environment side: producers and the fifo model.
    modport master (
        output s0_valid, s0_data, s1_valid, s1_data, fifo_full,
        input  s0_ready, s1_ready, fifo_wr_en, fifo_data_in
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one sys_fifo write port
//               between two producers, with per-port accepted-word counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fifo_wr_arbiter_if.slave      bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1
);

    localparam int                BEAT_W     = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] C_MAX_BEAT = BEAT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t             st_q, st_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic               w_own_vld;
    logic               w_own_sel;
    logic               w_own_valid;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_xfer0;
    logic               w_xfer1;
    logic               w_xfer;
    logic [BEAT_W-1:0]  w_beat_c;
    logic [DATA_W-1:0]  w_data;

    // Owner selection; in IDLE a tie goes to the port not served last.
    always_comb begin
        w_own_vld = 1'b0;
        w_own_sel = 1'b0;
        case (st_q)
            ST_GNT0: w_own_vld = 1'b1;
            ST_GNT1: begin
                w_own_vld = 1'b1;
                w_own_sel = 1'b1;
            end
            default: begin
                if (bus.s0_valid && bus.s1_valid) begin
                    w_own_vld = 1'b1;
                    w_own_sel = ~last_q;
                end else if (bus.s0_valid) begin
                    w_own_vld = 1'b1;
                end else if (bus.s1_valid) begin
                    w_own_vld = 1'b1;
                    w_own_sel = 1'b1;
                end
            end
        endcase
    end

    assign w_own_valid = w_own_sel ? bus.s1_valid : bus.s0_valid;
    assign w_ready0    = w_own_vld & ~w_own_sel & ~bus.fifo_full;
    assign w_ready1    = w_own_vld &  w_own_sel & ~bus.fifo_full;
    assign w_xfer0     = bus.s0_valid & w_ready0;
    assign w_xfer1     = bus.s1_valid & w_ready1;
    assign w_xfer      = w_xfer0 | w_xfer1;
    assign w_data      = !w_own_vld ? '0 : (w_own_sel ? bus.s1_data : bus.s0_data);

    assign bus.s0_ready     = w_ready0;
    assign bus.s1_ready     = w_ready1;
    assign bus.fifo_wr_en   = w_xfer;
    assign bus.fifo_data_in = w_data;

    // Next state: a full burst returns to IDLE on its last beat so the
    // following cycle re-arbitrates without a bubble.
    always_comb begin
        st_d     = st_q;
        beat_d   = beat_q;
        last_d   = last_q;
        w_beat_c = (st_q == ST_IDLE) ? BEAT_W'(1) : beat_q + BEAT_W'(1);
        if (w_xfer) begin
            if (w_beat_c == C_MAX_BEAT) begin
                st_d   = ST_IDLE;
                beat_d = '0;
                last_d = w_own_sel;
            end else begin
                st_d   = w_own_sel ? ST_GNT1 : ST_GNT0;
                beat_d = w_beat_c;
            end
        end else if (st_q != ST_IDLE && !w_own_valid) begin
            st_d   = ST_IDLE;
            beat_d = '0;
            last_d = w_own_sel;
        end
        cnt0_d = cnt0_q + CNT_W'(w_xfer0);
        cnt1_d = cnt1_q + CNT_W'(w_xfer1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            beat_q <= '0;
            last_q <= 1'b1;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            st_q   <= st_d;
            beat_q <= beat_d;
            last_q <= last_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign busy = (st_q != ST_IDLE);
    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             busy;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_checks = 0;
    int n_fails  = 0;

    fifo_wr_arbiter_if #(.DATA_W(DATA_W)) bus ();

    fifo_wr_arbiter #(
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        bus.s0_data  = '0;
        bus.s1_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fails++; $display("FAIL reset_wr_en got %b exp 0", bus.fifo_wr_en); end
        n_checks++; if (bus.s0_ready !== 1'b0) begin n_fails++; $display("FAIL reset_s0_ready got %b exp 0", bus.s0_ready); end
        n_checks++; if (bus.s1_ready !== 1'b0) begin n_fails++; $display("FAIL reset_s1_ready got %b exp 0", bus.s1_ready); end
        n_checks++; if (bus.fifo_data_in !== 16'h0) begin n_fails++; $display("FAIL reset_data_in got %h exp 0", bus.fifo_data_in); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (cnt0 !== 16'd0) begin n_fails++; $display("FAIL reset_cnt0 got %0d exp 0", cnt0); end
        n_checks++; if (cnt1 !== 16'd0) begin n_fails++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
    endtask

    task automatic test_stream();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            bus.s0_valid = 1'b1;
            bus.s0_data  = 16'(3 + i);
            #1;
            n_checks++; if (bus.fifo_wr_en !== 1'b1) begin n_fails++; $display("FAIL stream_wr_en[%0d] got %b exp 1", i, bus.fifo_wr_en); end
            n_checks++; if (bus.fifo_data_in !== 16'(3 + i)) begin n_fails++; $display("FAIL stream_data[%0d] got %0d exp %0d", i, bus.fifo_data_in, 3 + i); end
            n_checks++; if (bus.s1_ready !== 1'b0) begin n_fails++; $display("FAIL stream_s1_ready[%0d] got %b exp 0", i, bus.s1_ready); end
            cyc();
        end
        bus.s0_valid = 1'b0;
        #1;
        n_checks++; if (cnt0 !== 16'd10) begin n_fails++; $display("FAIL stream_cnt0 got %0d exp 10", cnt0); end
        n_checks++; if (cnt1 !== 16'd0) begin n_fails++; $display("FAIL stream_cnt1 got %0d exp 0", cnt1); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL stream_busy_mid got %b exp 1", busy); end
        cyc();
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL stream_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        int n0 = 0;
        int n1 = 0;
        int own;
        logic [DATA_W-1:0] exp_data;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            bus.s0_valid = 1'b1;
            bus.s1_valid = 1'b1;
            bus.s0_data  = 16'(16'h1000 + n0);
            bus.s1_data  = 16'(16'h2000 + n1);
            own      = (k / 4) % 2;
            exp_data = (own == 0) ? 16'(16'h1000 + n0) : 16'(16'h2000 + n1);
            #1;
            n_checks++; if (bus.s0_ready !== (own == 0)) begin n_fails++; $display("FAIL rr_s0_ready[%0d] got %b exp %b", k, bus.s0_ready, own == 0); end
            n_checks++; if (bus.s1_ready !== (own == 1)) begin n_fails++; $display("FAIL rr_s1_ready[%0d] got %b exp %b", k, bus.s1_ready, own == 1); end
            n_checks++; if (bus.fifo_data_in !== exp_data) begin n_fails++; $display("FAIL rr_data[%0d] got %h exp %h", k, bus.fifo_data_in, exp_data); end
            if (own == 0) n0++; else n1++;
            cyc();
        end
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        #1;
        n_checks++; if (cnt0 !== 16'd8) begin n_fails++; $display("FAIL rr_cnt0 got %0d exp 8", cnt0); end
        n_checks++; if (cnt1 !== 16'd8) begin n_fails++; $display("FAIL rr_cnt1 got %0d exp 8", cnt1); end
    endtask

    task automatic test_full_stall();
        apply_reset();
        bus.s0_valid = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            bus.s0_data = 16'(16'hA000 + b);
            if (b == 3) begin
                bus.fifo_full = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    n_checks++; if (bus.s0_ready !== 1'b0) begin n_fails++; $display("FAIL stall_ready[%0d] got %b exp 0", s, bus.s0_ready); end
                    n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fails++; $display("FAIL stall_wr_en[%0d] got %b exp 0", s, bus.fifo_wr_en); end
                    n_checks++; if (bus.fifo_data_in !== 16'hA003) begin n_fails++; $display("FAIL stall_data[%0d] got %h exp a003", s, bus.fifo_data_in); end
                    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL stall_busy[%0d] got %b exp 1", s, busy); end
                    cyc();
                end
                bus.fifo_full = 1'b0;
            end
            #1;
            n_checks++; if (bus.fifo_wr_en !== 1'b1) begin n_fails++; $display("FAIL stall_beat_wr_en[%0d] got %b exp 1", b, bus.fifo_wr_en); end
            n_checks++; if (bus.fifo_data_in !== 16'(16'hA000 + b)) begin n_fails++; $display("FAIL stall_beat_data[%0d] got %h exp %h", b, bus.fifo_data_in, 16'(16'hA000 + b)); end
            cyc();
        end
        bus.s0_valid = 1'b0;
        #1;
        n_checks++; if (cnt0 !== 16'd4) begin n_fails++; $display("FAIL stall_cnt0 got %0d exp 4", cnt0); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL stall_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_drop_valid();
        apply_reset();
        bus.s0_valid = 1'b1;
        bus.s0_data  = 16'hB000;
        bus.s1_valid = 1'b1;
        bus.s1_data  = 16'hC000;
        #1;
        n_checks++; if (bus.s0_ready !== 1'b1) begin n_fails++; $display("FAIL drop_first_s0_ready got %b exp 1", bus.s0_ready); end
        cyc();
        bus.s0_valid = 1'b0;
        #1;
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fails++; $display("FAIL drop_dead_wr_en got %b exp 0", bus.fifo_wr_en); end
        n_checks++; if (bus.s1_ready !== 1'b0) begin n_fails++; $display("FAIL drop_dead_s1_ready got %b exp 0", bus.s1_ready); end
        cyc();
        n_checks++; if (bus.s1_ready !== 1'b1) begin n_fails++; $display("FAIL drop_s1_ready got %b exp 1", bus.s1_ready); end
        n_checks++; if (bus.fifo_data_in !== 16'hC000) begin n_fails++; $display("FAIL drop_s1_data got %h exp c000", bus.fifo_data_in); end
        cyc();
        bus.s1_valid = 1'b0;
        #1;
        n_checks++; if (cnt0 !== 16'd1) begin n_fails++; $display("FAIL drop_cnt0 got %0d exp 1", cnt0); end
        n_checks++; if (cnt1 !== 16'd1) begin n_fails++; $display("FAIL drop_cnt1 got %0d exp 1", cnt1); end
    endtask

    task automatic test_mid_reset();
        int n0 = 0;
        int n1 = 0;
        apply_reset();
        bus.s0_valid = 1'b1;
        bus.s1_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.s0_data = 16'(16'h3000 + n0);
            bus.s1_data = 16'(16'h4000 + n1);
            if (k < 4) n0++; else n1++;
            cyc();
        end
        bus.s0_data = 16'(16'h3000 + n0);
        bus.s1_data = 16'(16'h4000 + n1);
        #1;
        n_checks++; if (bus.s1_ready !== 1'b1) begin n_fails++; $display("FAIL mrst_pre_s1_ready got %b exp 1", bus.s1_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL mrst_pre_busy got %b exp 1", busy); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL mrst_busy got %b exp 0", busy); end
        n_checks++; if (cnt0 !== 16'd0) begin n_fails++; $display("FAIL mrst_cnt0 got %0d exp 0", cnt0); end
        n_checks++; if (cnt1 !== 16'd0) begin n_fails++; $display("FAIL mrst_cnt1 got %0d exp 0", cnt1); end
        n_checks++; if (bus.s0_ready !== 1'b1) begin n_fails++; $display("FAIL mrst_s0_ready got %b exp 1", bus.s0_ready); end
        n_checks++; if (bus.s1_ready !== 1'b0) begin n_fails++; $display("FAIL mrst_s1_ready got %b exp 0", bus.s1_ready); end
        n_checks++; if (bus.fifo_data_in !== 16'h3004) begin n_fails++; $display("FAIL mrst_data got %h exp 3004", bus.fifo_data_in); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_round_robin();
        test_full_stall();
        test_drop_valid();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
